// File: rtl/muldiv_iter_unit.sv
// ---------------------------------------------------------------------------
// muldiv_iter_unit
//
// Iterative RV32M/RV64M multiply/divide engine. A single 2*XLEN accumulator
// is shared by a shift-add multiplier and a restoring divider, and BPC bits
// are retired per CALC cycle. The unit works on operand magnitudes and
// applies sign correction when the result is registered for FIN.
//
// Parameters:
//   XLEN  - operand/result width (32 or 64)
//   BPC   - bits retired per CALC cycle (1, 2 or 4; must divide XLEN)
//   TAG_W - width of the tag carried alongside the op
//
// Ports:
//   clk     in   system clock, rising edge
//   Rst     in   synchronous reset, active-high
//   hold    in   freeze all state (pipeline stall)
//   flush   in   abort the current op, no done pulse
//   start   in   request, sampled only in IDLE
//   op      in   funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b    in   rs1 / rs2 operands
//   tag_in  in   tag captured at start
//   busy    out  high whenever the unit is not IDLE
//   done    out  result valid, high only in FIN
//   res     out  result, held until the next FIN or Rst
//   tag_out out  tag of the op in flight or just completed
//
// Optional feature (macro MULDIV_OPCACHE_EN): keeps the operands, op pair
// and full result of the last completed op, so that the companion op of the
// same pair on identical operands (e.g. REM after DIV) completes from IDLE
// straight to FIN without any CALC cycles.
// ---------------------------------------------------------------------------
module muldiv_iter_unit #(
    parameter int XLEN  = 32,
    parameter int BPC   = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  res,
    output logic [TAG_W-1:0] tag_out
);

    localparam int N  = XLEN / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Full results are laid out as {high, low}: for a multiply that is the
    // 2*XLEN product, for a divide it is {remainder, quotient}. One selector
    // then serves every op.
    function automatic logic [XLEN-1:0] pick(input logic [2:0]        f,
                                             input logic [2*XLEN-1:0] full);
        if (f[2])
            pick = f[1] ? full[2*XLEN-1:XLEN] : full[XLEN-1:0];
        else
            pick = (f[1:0] == 2'b00) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    endfunction

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*XLEN-1:0]  acc;      // {partial product | remainder, multiplier | dividend/quotient}
    logic [XLEN-1:0]    mb;       // multiplicand or divisor magnitude
    logic [2:0]         op_q;
    logic               sa_q;
    logic               sb_q;

    // ---------------- IDLE-side operand decode ----------------
    logic              signed_a;
    logic              signed_b;
    logic              sa_in;
    logic              sb_in;
    logic [XLEN-1:0]   ma_in;
    logic [XLEN-1:0]   mb_in;
    logic              div_by_zero;
    logic              div_ovf;
    logic              special;
    logic [2*XLEN-1:0] spec_full;

    assign signed_a    = (op == OP_MULH) || (op == OP_MULHSU) ||
                         (op == OP_DIV)  || (op == OP_REM);
    assign signed_b    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign sa_in       = signed_a & a[XLEN-1];
    assign sb_in       = signed_b & b[XLEN-1];
    assign ma_in       = sa_in ? -a : a;
    assign mb_in       = sb_in ? -b : b;
    assign div_by_zero = op[2] && (b == '0);
    assign div_ovf     = op[2] && !op[0] &&
                         (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign special     = div_by_zero || div_ovf;
    assign spec_full   = div_by_zero ? {a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a};

    // ---------------- iteration step ----------------
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     r_sh;
    logic [XLEN:0]     diff;
    logic [XLEN:0]     sum;

    // NOTE: every variable written in an always_comb block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        acc_step = acc;
        r_sh     = '0;
        diff     = '0;
        sum      = '0;
        for (int i = 0; i < BPC; i++) begin
            if (op_q[2]) begin
                // Restoring divide: shift the next dividend bit into the
                // remainder and keep the difference only if it did not borrow.
                r_sh = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
                diff = r_sh - {1'b0, mb};
                if (!diff[XLEN])
                    acc_step = {diff[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
                else
                    acc_step = {r_sh[XLEN-1:0], acc_step[XLEN-2:0], 1'b0};
            end else begin
                // Shift-add multiply: the carry of the add becomes the top
                // bit of the right-shifted accumulator.
                sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} +
                           (acc_step[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});
                acc_step = {sum, acc_step[XLEN-1:1]};
            end
        end
    end

    // ---------------- sign correction ----------------
    logic [XLEN-1:0]   quot_mag;
    logic [XLEN-1:0]   rem_mag;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [2*XLEN-1:0] prod_fix;
    logic [2*XLEN-1:0] calc_full;

    assign quot_mag  = acc_step[XLEN-1:0];
    assign rem_mag   = acc_step[2*XLEN-1:XLEN];
    assign quot_fix  = (sa_q ^ sb_q) ? -quot_mag : quot_mag;
    assign rem_fix   = sa_q ? -rem_mag : rem_mag;        // remainder follows dividend
    assign prod_fix  = (sa_q ^ sb_q) ? -acc_step : acc_step;
    assign calc_full = op_q[2] ? {rem_fix, quot_fix} : prod_fix;

`ifdef MULDIV_OPCACHE_EN
    // Ops that share one full result: {MULH}, {MULHU, MUL}, {MULHSU},
    // {DIV, REM}, {DIVU, REMU}.
    function automatic logic [2:0] op_pair(input logic [2:0] f);
        case (f)
            3'b001:          op_pair = 3'd0;
            3'b000, 3'b011:  op_pair = 3'd1;
            3'b010:          op_pair = 3'd2;
            3'b100, 3'b110:  op_pair = 3'd3;
            default:         op_pair = 3'd4;
        endcase
    endfunction

    logic              c_valid;
    logic [XLEN-1:0]   c_a;
    logic [XLEN-1:0]   c_b;
    logic [2:0]        c_pair;
    logic [2*XLEN-1:0] c_full;
    logic              hit;

    assign hit = c_valid && (a == c_a) && (b == c_b) && (op_pair(op) == c_pair);
`endif

    // ---------------- state, datapath and outputs ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mb      <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            res     <= '0;
            tag_out <= '0;
`ifdef MULDIV_OPCACHE_EN
            c_valid <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_pair  <= '0;
            c_full  <= '0;
`endif
        end else if (flush) begin
            // Abort: no done pulse, res keeps its last completed value.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MULDIV_OPCACHE_EN
            c_valid <= 1'b0;
`endif
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        sa_q    <= sa_in;
                        sb_q    <= sb_in;
                        mb      <= mb_in;
                        acc     <= {{XLEN{1'b0}}, ma_in};
                        tag_out <= tag_in;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        if (special) begin
                            state <= FIN;
                            done  <= 1'b1;
                            res   <= pick(op, spec_full);
`ifdef MULDIV_OPCACHE_EN
                            c_a     <= a;
                            c_b     <= b;
                            c_pair  <= op_pair(op);
                            c_full  <= spec_full;
                            c_valid <= 1'b1;
`endif
                        end
`ifdef MULDIV_OPCACHE_EN
                        else if (hit) begin
                            state <= FIN;
                            done  <= 1'b1;
                            res   <= pick(op, c_full);
                        end
`endif
                        else begin
                            state <= CALC;
`ifdef MULDIV_OPCACHE_EN
                            // The entry is re-tagged now and becomes valid
                            // once this op reaches FIN.
                            c_a     <= a;
                            c_b     <= b;
                            c_pair  <= op_pair(op);
                            c_valid <= 1'b0;
`endif
                        end
                    end
                end

                CALC: begin
                    acc <= acc_step;
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= FIN;
                        done  <= 1'b1;
                        res   <= pick(op_q, calc_full);
`ifdef MULDIV_OPCACHE_EN
                        c_full  <= calc_full;
                        c_valid <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_iter_unit
//
// Drives three instances in lockstep: XLEN=32/BPC=1, XLEN=32/BPC=4 and
// XLEN=64/BPC=1. A table of directed vectors with hand-computed results is
// applied to all three, followed by hand-written sequences for hold, flush,
// start-while-busy and the optional operand cache.
// ---------------------------------------------------------------------------
module tb_muldiv_iter_unit;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

`ifdef MULDIV_OPCACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        Rst;
    logic        hold;
    logic        flush;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a32, b32;
    logic [63:0] a64, b64;
    logic [4:0]  tag;

    logic        busy32, done32, busy4, done4, busy64, done64;
    logic [31:0] res32, res4;
    logic [63:0] res64;
    logic [4:0]  tag32, tag4, tag64;

    always #5 clk = ~clk;

    muldiv_iter_unit #(.XLEN(32), .BPC(1), .TAG_W(5)) dut (
        .clk(clk), .Rst(Rst), .hold(hold), .flush(flush), .start(start),
        .op(op), .a(a32), .b(b32), .tag_in(tag),
        .busy(busy32), .done(done32), .res(res32), .tag_out(tag32)
    );

    muldiv_iter_unit #(.XLEN(32), .BPC(4), .TAG_W(5)) dut4 (
        .clk(clk), .Rst(Rst), .hold(hold), .flush(flush), .start(start),
        .op(op), .a(a32), .b(b32), .tag_in(tag),
        .busy(busy4), .done(done4), .res(res4), .tag_out(tag4)
    );

    muldiv_iter_unit #(.XLEN(64), .BPC(1), .TAG_W(5)) dut64 (
        .clk(clk), .Rst(Rst), .hold(hold), .flush(flush), .start(start),
        .op(op), .a(a64), .b(b64), .tag_in(tag),
        .busy(busy64), .done(done64), .res(res64), .tag_out(tag64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the last run (cycle numbers count edges after start).
    int          d32, d4, d64;     // first cycle with done high, 0 = never
    int          bc32, dc32;       // cycles with busy / done high
    logic [31:0] r32, r4;
    logic [63:0] r64;
    logic [4:0]  t32;
    bit          fin;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op and observe until all instances are idle again.
    // hf/hl: hold window (first cycle, length); fa: flush cycle;
    // sa: cycle in which a stray start is presented. 0 disables each.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] x64, input logic [63:0] y64,
                          input logic [4:0] t, input bit keep,
                          input int hf, input int hl, input int fa, input int sa);
        if (!keep) begin
            @(negedge clk); flush = 1'b1;
            @(negedge clk); flush = 1'b0;
        end
        @(negedge clk);
        op = f; a32 = x; b32 = y; a64 = x64; b64 = y64; tag = t; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        d32 = 0; d4 = 0; d64 = 0; bc32 = 0; dc32 = 0;
        r32 = '0; r4 = '0; r64 = '0; t32 = '0; fin = 1'b0;
        for (int k = 1; k <= 200 && !fin; k++) begin
            @(negedge clk);
            if (busy32) bc32++;
            if (done32) begin
                dc32++;
                if (d32 == 0) begin d32 = k; r32 = res32; t32 = tag32; end
            end
            if (done4  && d4  == 0) begin d4  = k; r4  = res4;  end
            if (done64 && d64 == 0) begin d64 = k; r64 = res64; end
            if (k > 1 && !busy32 && !busy4 && !busy64) begin
                fin = 1'b1;
            end else begin
                hold  = (hl > 0) && (k >= hf) && (k < hf + hl);
                flush = (k == fa);
                if (k == sa) begin
                    start = 1'b1; op = DIVU; a32 = 1; b32 = 1; a64 = 1; b64 = 1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        hold = 1'b0; flush = 1'b0; start = 1'b0;
        check("run_completes", 64'(fin), 64'd1);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] a64;
        logic [63:0] b64;
        logic [31:0] e32;
        logic [63:0] e64;
        bit          spc;
    } vec_t;

    vec_t vecs[18];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 64'd7,                  64'hFFFFFFFFFFFFFFFD, 32'hFFFFFFEB, 64'hFFFFFFFFFFFFFFEB, 1'b0};
        vecs[1]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0};
        vecs[2]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF, 32'h00000000, 64'h0,                1'b0};
        vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'd2,        64'hFFFFFFFFFFFFFFF9,   64'd2,                32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFFD, 1'b0};
        vecs[5]  = '{REM,    32'hFFFFFFF9, 32'd2,        64'hFFFFFFFFFFFFFFF9,   64'd2,                32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[6]  = '{DIVU,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFFFFFFFFF9,   64'd2,                32'h7FFFFFFC, 64'h7FFFFFFFFFFFFFFC, 1'b0};
        vecs[7]  = '{DIV,    32'h1234,     32'd0,        64'h1234,               64'd0,                32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1};
        vecs[8]  = '{REMU,   32'h1234,     32'd0,        64'h1234,               64'd0,                32'h00001234, 64'h1234,             1'b1};
        vecs[9]  = '{DIV,    32'h80000000, 32'hFFFFFFFF, 64'h8000000000000000,   64'hFFFFFFFFFFFFFFFF, 32'h80000000, 64'h8000000000000000, 1'b1};
        vecs[10] = '{REM,    32'h80000000, 32'hFFFFFFFF, 64'h8000000000000000,   64'hFFFFFFFFFFFFFFFF, 32'h00000000, 64'h0,                1'b1};
        vecs[11] = '{MULH,   32'h80000000, 32'h80000000, 64'h8000000000000000,   64'h8000000000000000, 32'h40000000, 64'h4000000000000000, 1'b0};
        vecs[12] = '{DIV,    32'd7,        32'hFFFFFFFE, 64'd7,                  64'hFFFFFFFFFFFFFFFE, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFFD, 1'b0};
        vecs[13] = '{REM,    32'd7,        32'hFFFFFFFE, 64'd7,                  64'hFFFFFFFFFFFFFFFE, 32'h00000001, 64'h1,                1'b0};
        vecs[14] = '{MULHSU, 32'd2,        32'h80000000, 64'd2,                  64'h8000000000000000, 32'h00000001, 64'h1,                1'b0};
        vecs[15] = '{DIVU,   32'd100,      32'd7,        64'd100,                64'd7,                32'd14,       64'd14,               1'b0};
        vecs[16] = '{REMU,   32'd100,      32'd7,        64'd100,                64'd7,                32'd2,        64'd2,                1'b0};
        vecs[17] = '{MUL,    32'h00010000, 32'h00010000, 64'h10000,              64'h10000,            32'h00000000, 64'h100000000,        1'b0};

        Rst = 1'b1; hold = 1'b0; flush = 1'b0; start = 1'b0;
        op = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0; tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        Rst = 1'b0;
        check("reset_busy",    64'(busy32), 64'd0);
        check("reset_done",    64'(done32), 64'd0);
        check("reset_res",     64'(res32),  64'd0);
        check("reset_tag",     64'(tag32),  64'd0);
        check("reset_res64",   res64,       64'd0);

        // Directed table, applied to all three configurations.
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].a64, vecs[i].b64,
                   5'(i + 3), 1'b0, 0, 0, 0, 0);
            check($sformatf("v%0d_res32", i),  64'(r32), 64'(vecs[i].e32));
            check($sformatf("v%0d_done32", i), 64'(d32), vecs[i].spc ? 64'd1 : 64'd33);
            check($sformatf("v%0d_busy32", i), 64'(bc32), vecs[i].spc ? 64'd1 : 64'd33);
            check($sformatf("v%0d_ndone", i),  64'(dc32), 64'd1);
            check($sformatf("v%0d_tag", i),    64'(t32), 64'(i + 3));
            check($sformatf("v%0d_res4", i),   64'(r4),  64'(vecs[i].e32));
            check($sformatf("v%0d_done4", i),  64'(d4),  vecs[i].spc ? 64'd1 : 64'd9);
            check($sformatf("v%0d_res64", i),  r64,      vecs[i].e64);
            check($sformatf("v%0d_done64", i), 64'(d64), vecs[i].spc ? 64'd1 : 64'd65);
        end

        // Hold for five cycles in CALC stretches the latency 1:1.
        run_op(MUL, 32'd7, 32'hFFFFFFFD, 64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd20, 1'b0, 5, 5, 0, 0);
        check("hold_calc_done",  64'(d32),  64'd38);
        check("hold_calc_res",   64'(r32),  64'hFFFFFFEB);
        check("hold_calc_busy",  64'(bc32), 64'd38);

        // Hold while in FIN keeps done asserted.
        run_op(DIVU, 32'd100, 32'd7, 64'd100, 64'd7, 5'd21, 1'b0, 33, 3, 0, 0);
        check("hold_fin_done",   64'(d32),  64'd33);
        check("hold_fin_ndone",  64'(dc32), 64'd4);
        check("hold_fin_res",    64'(r32),  64'd14);
        check("hold_fin_busy",   64'(bc32), 64'd36);

        // A start presented while busy is ignored.
        run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
               5'd22, 1'b0, 0, 0, 0, 5);
        check("busy_start_res",   64'(r32),  64'hFFFFFFFE);
        check("busy_start_done",  64'(d32),  64'd33);
        check("busy_start_busy",  64'(bc32), 64'd33);
        check("busy_start_res4",  64'(r4),   64'hFFFFFFFE);
        check("busy_start_done4", 64'(d4),   64'd9);

        // Flush in cycle 10: busy drops in cycle 11, no done, res untouched.
        run_op(DIV, 32'd100, 32'd7, 64'd100, 64'd7, 5'd23, 1'b0, 0, 0, 10, 0);
        check("flush_ndone",     64'(dc32),  64'd0);
        check("flush_busy",      64'(bc32),  64'd10);
        check("flush_res_kept",  64'(res32), 64'hFFFFFFFE);

        // Operand cache: REM after DIV on the same operands.
        run_op(DIV, 32'd100, 32'd7, 64'd100, 64'd7, 5'd24, 1'b0, 0, 0, 0, 0);
        check("cache_div_res",   64'(r32), 64'd14);
        check("cache_div_done",  64'(d32), 64'd33);
        run_op(REM, 32'd100, 32'd7, 64'd100, 64'd7, 5'd25, 1'b1, 0, 0, 0, 0);
        check("cache_rem_res",   64'(r32), 64'd2);
        check("cache_rem_done",  64'(d32), 64'(HIT_LAT));
        check("cache_rem_tag",   64'(t32), 64'd25);
        run_op(REM, 32'd100, 32'd7, 64'd100, 64'd7, 5'd26, 1'b0, 0, 0, 0, 0);
        check("cache_flushed_res",  64'(r32), 64'd2);
        check("cache_flushed_done", 64'(d32), 64'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
